cb_config_chain: RTL

CB_CONFIG_CHAIN -- requirements
Module: cb_config_chain

---
 rtl/cb_config_chain.sv | 119 +++++++++++
 1 files changed

// File: rtl/cb_config_chain.sv
// cb_config_chain
// ---------------
// Configuration shift chain for one connection block. Words shift serially
// into a shadow register while cfg_en is high, then a commit copies the
// shadow into the active register that drives the connection block's c bus.
// A capture copies the active configuration back into the shadow so it can
// be shifted out for readback. Blocks daisy-chain through cfg_out.
//
// Parameters
//   CFG_W   : number of configuration bits on c
//   WORD_W  : bits shifted per enabled cycle (1..32)
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   cfg_en   in   shift one word this cycle
//   cfg_in   in   [WORD_W] word entering the chain
//   cfg_out  out  [WORD_W] word leaving the chain on the next shift
//   commit   in   copy shadow to active (only when full)
//   capture  in   copy active to shadow for readback
//   err_clr  in   clear the sticky error flag
//   c        out  [CFG_W] active configuration (registered)
//   c_valid  out  high once any commit has succeeded
//   full     out  shadow holds a complete NWORDS-word load
//   cfg_err  out  sticky error flag
//
// Control priority, highest first:
//   commit & capture -> nothing acts, error raised
//   capture          -> shadow <= active (zero padded), count <= NWORDS
//   commit           -> if full: active <= shadow, c_valid, count <= 0
//                       else error; the shadow is left untouched either way
//   cfg_en           -> shift one word, count saturates at NWORDS
module cb_config_chain #(
    parameter int CFG_W  = 202,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [WORD_W-1:0] cfg_in,
    output logic [WORD_W-1:0] cfg_out,
    input  logic              commit,
    input  logic              capture,
    input  logic              err_clr,
    output logic [CFG_W-1:0]  c,
    output logic              c_valid,
    output logic              full,
    output logic              cfg_err
);

    localparam int NWORDS   = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int SHADOW_W = NWORDS * WORD_W;
    localparam int CNT_W    = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NWORDS);

    logic [SHADOW_W-1:0] shadow;
    logic [SHADOW_W-1:0] shadow_shift;
    logic [SHADOW_W-1:0] shadow_cap;
    logic [CFG_W-1:0]    active;
    logic [CNT_W-1:0]    count;
    logic                err_set;

    // Next shadow on a shift: every word moves down one slot and the new
    // word enters at the top, so the oldest word sits in the bottom slot
    // and is what cfg_out presents to the next block.
    always_comb begin
        shadow_shift = '0;
        for (int i = 0; i < NWORDS - 1; i++) begin
            shadow_shift[i*WORD_W +: WORD_W] = shadow[(i+1)*WORD_W +: WORD_W];
        end
        shadow_shift[(NWORDS-1)*WORD_W +: WORD_W] = cfg_in;
    end

    // Readback image: active configuration with pad bits forced to zero.
    always_comb begin
        shadow_cap              = '0;
        shadow_cap[CFG_W-1:0]   = active;
    end

    assign full    = (count == CNT_FULL);
    assign err_set = commit & (capture | ~full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            count   <= '0;
            c_valid <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            // A new error wins over a concurrent clear.
            cfg_err <= err_set | (cfg_err & ~err_clr);

            if (commit && capture) begin
                // Conflicting request: hold all state, error flagged above.
            end else if (capture) begin
                shadow <= shadow_cap;
                count  <= CNT_FULL;
            end else if (commit) begin
                // Acts on the pre-shift shadow; any concurrent shift is lost.
                if (full) begin
                    active  <= shadow[CFG_W-1:0];
                    c_valid <= 1'b1;
                    count   <= '0;
                end
            end else if (cfg_en) begin
                shadow <= shadow_shift;
                // Shifts beyond a full load are daisy-chain pass-through.
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign c       = active;
    assign cfg_out = shadow[WORD_W-1:0];

endmodule
